// File: rtl/sr_bank_pkg.sv
// Shared constants and helpers for the SR register bank: S=R=1 resolution modes
// and the saturating conflict-counter increment.
package sr_bank_pkg;

   localparam int SR_RST_DOM = 0;
   localparam int SR_SET_DOM = 1;
   localparam int SR_TOGGLE  = 2;
   localparam int SR_HOLD    = 3;

   // Next Q for a channel that sees S=R=1, given the configured resolution mode.
   function automatic logic sr_resolve(input int mode, input logic q_cur);
      case (mode)
         SR_RST_DOM: return 1'b0;
         SR_SET_DOM: return 1'b1;
         SR_TOGGLE:  return ~q_cur;
         default:    return q_cur;
      endcase
   endfunction

   function automatic logic [15:0] conflict_sat_inc(input logic [15:0] cnt,
                                                    input logic [15:0] max_val);
      if (cnt >= max_val) return max_val;
      return cnt + 16'd1;
   endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: registered state, 0->1 edge pulse and sticky conflict flag.
module sr_cell
   import sr_bank_pkg::*;
#(
   parameter int MODE = SR_RST_DOM
) (
   input  logic clk,
   input  logic clear,
   input  logic en,
   input  logic s,
   input  logic r,
   input  logic ack,
   output logic q,
   output logic q_rise,
   output logic conflict
);

   logic q_d, q_q;
   logic rise_d, rise_q;
   logic cf_d, cf_q;
   logic hit;

   assign hit = en & s & r;

   always_comb begin
      q_d = q_q;
      if (en) begin
         case ({s, r})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = sr_resolve(MODE, q_q);
            default: q_d = q_q;
         endcase
      end
      rise_d = q_d & ~q_q;
      // A new conflict outranks an acknowledge on the same edge.
      cf_d = hit | (cf_q & ~ack);
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         q_q    <= 1'b0;
         rise_q <= 1'b0;
         cf_q   <= 1'b0;
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
         cf_q   <= cf_d;
      end
   end

   assign q        = q_q;
   assign q_rise   = rise_q;
   assign conflict = cf_q;

endmodule

// File: rtl/sr_register_bank.sv
// Bank of N independent SR channels with a shared saturating conflict counter.
// Counter is built only when SR_BANK_CONFLICT_CNT_EN is defined; otherwise it reads 0.
module sr_register_bank
   import sr_bank_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = SR_RST_DOM,
   parameter int CW   = 8
) (
   input  logic          clk,
   input  logic          clear,
   input  logic [N-1:0]  En,
   input  logic [N-1:0]  S,
   input  logic [N-1:0]  R,
   input  logic [N-1:0]  conflict_ack,
   output logic [N-1:0]  Q,
   output logic [N-1:0]  Qbar,
   output logic [N-1:0]  q_rise,
   output logic [N-1:0]  conflict,
   output logic [CW-1:0] conflict_count
);

   for (genvar i = 0; i < N; i++) begin : g_cell
      sr_cell #(.MODE(MODE)) u_cell (
         .clk      (clk),
         .clear    (clear),
         .en       (En[i]),
         .s        (S[i]),
         .r        (R[i]),
         .ack      (conflict_ack[i]),
         .q        (Q[i]),
         .q_rise   (q_rise[i]),
         .conflict (conflict[i])
      );
   end

   assign Qbar = ~Q;

`ifdef SR_BANK_CONFLICT_CNT_EN
   localparam logic [15:0] CNT_MAX = 16'((32'd1 << CW) - 32'd1);

   logic [CW-1:0] cnt_d, cnt_q;
   logic [15:0]   cnt_next;

   // One increment per edge with any conflicting channel, not one per channel.
   always_comb begin
      cnt_next = conflict_sat_inc(16'(cnt_q), CNT_MAX);
      cnt_d    = cnt_q;
      if (|(En & S & R)) cnt_d = cnt_next[CW-1:0];
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign conflict_count = cnt_q;
`else
   assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_sr_register_bank.sv
// Bench for sr_register_bank: four instances (one per S=R=1 mode) against a behavioural model.
module tb_sr_register_bank;

`ifdef SR_BANK_CONFLICT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clear;
   logic [7:0] en, s, r, ack;
   logic [7:0] q_w[4], qb_w[4], rise_w[4], cf_w[4], cnt_w[4];
   logic       started = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      localparam int CWM = (m == 2) ? 2 : 8;
      logic [CWM-1:0] cnt_l;
      sr_register_bank #(.N(8), .MODE(m), .CW(CWM)) u_dut (
         .clk            (clk),
         .clear          (clear),
         .En             (en),
         .S              (s),
         .R              (r),
         .conflict_ack   (ack),
         .Q              (q_w[m]),
         .Qbar           (qb_w[m]),
         .q_rise         (rise_w[m]),
         .conflict       (cf_w[m]),
         .conflict_count (cnt_l)
      );
      assign cnt_w[m] = 8'(cnt_l);
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: channel state as plain bit vectors, counter as an int.
   logic [7:0] mq[4], mcf[4], mrise[4];
   int         mcnt[4];
   logic [7:0] nq;
   always @(posedge clk or posedge clear) begin
      if (clear) begin
         for (int m = 0; m < 4; m++) begin
            mq[m] = 8'h00; mcf[m] = 8'h00; mrise[m] = 8'h00; mcnt[m] = 0;
         end
      end else begin
         for (int m = 0; m < 4; m++) begin
            nq = mq[m];
            for (int i = 0; i < 8; i++) begin
               if (en[i]) begin
                  if (s[i] && !r[i]) nq[i] = 1'b1;
                  else if (!s[i] && r[i]) nq[i] = 1'b0;
                  else if (s[i] && r[i]) begin
                     if (m == 0) nq[i] = 1'b0;
                     else if (m == 1) nq[i] = 1'b1;
                     else if (m == 2) nq[i] = ~mq[m][i];
                  end
               end
            end
            mrise[m] = nq & ~mq[m];
            mq[m]    = nq;
            mcf[m]   = (en & s & r) | (mcf[m] & ~ack);
            if (CNT_EN && ((en & s & r) != 8'h00) && mcnt[m] < ((m == 2) ? 3 : 255))
               mcnt[m]++;
         end
      end
   end

   always @(negedge clk) begin
      if (started && !clear) begin
         for (int m = 0; m < 4; m++) begin
            chk($sformatf("Q_m%0d", m), q_w[m], mq[m]);
            chk($sformatf("Qbar_m%0d", m), qb_w[m], ~mq[m]);
            chk($sformatf("q_rise_m%0d", m), rise_w[m], mrise[m]);
            chk($sformatf("conflict_m%0d", m), cf_w[m], mcf[m]);
            chk($sformatf("count_m%0d", m), cnt_w[m], 8'(mcnt[m]));
         end
      end
   end

   // Apply one input vector, let one rising edge sample it, return mid low phase.
   task automatic cyc(input logic [7:0] e, input logic [7:0] sv, input logic [7:0] rv,
                      input logic [7:0] av);
      en = e; s = sv; r = rv; ack = av;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_clear();
      #1 clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1 clear = 1'b0;
   endtask

   logic [7:0] saved;
   int         exp_cnt[6];

   initial begin
      clear = 1'b0; en = 0; s = 0; r = 0; ack = 0;
      #1 clear = 1'b1;
      #15;
      chk("rst_Q", q_w[0], 8'h00);
      chk("rst_Qbar", qb_w[0], 8'hFF);
      chk("rst_rise", rise_w[0], 8'h00);
      chk("rst_conflict", cf_w[0], 8'h00);
      chk("rst_count", cnt_w[0], 8'h00);
      @(negedge clk); #1;
      clear = 1'b0;
      started = 1'b1;

      // Split set/reset across the byte.
      cyc(8'hFF, 8'h0F, 8'hF0, 8'h00);
      chk("split_Q", q_w[0], 8'h0F);
      chk("split_rise", rise_w[0], 8'h0F);
      cyc(8'h00, 8'h00, 8'h00, 8'h00);
      chk("split_rise_drop", rise_w[0], 8'h00);
      chk("split_hold", q_w[0], 8'h0F);
      cyc(8'hFF, 8'hFF, 8'h00, 8'h00);
      chk("setall_rise", rise_w[0], 8'hF0);
      cyc(8'hFF, 8'h00, 8'hAA, 8'h00);
      chk("rstodd_Q", q_w[0], 8'h55);

      // Build Q=A5 with a live conflict, then clear between edges.
      cyc(8'h08, 8'h08, 8'h08, 8'h00);
      cyc(8'hFF, 8'hA5, 8'h5A, 8'h00);
      chk("pre_clear_Q", q_w[0], 8'hA5);
      chk("pre_clear_cf", cf_w[0], 8'h08);
      en = 8'hFF; s = 8'hFF; r = 8'h00;
      #1 clear = 1'b1;
      #1;
      chk("async_Q", q_w[0], 8'h00);
      chk("async_Qbar", qb_w[0], 8'hFF);
      chk("async_conflict", cf_w[0], 8'h00);
      chk("async_count", cnt_w[0], 8'h00);
      @(posedge clk);
      #2;
      chk("clear_ignores_in", q_w[0], 8'h00);
      @(negedge clk); #1;
      en = 0; s = 0; r = 0;
      clear = 1'b0;

      // Toggle mode: three conflicting edges on channel 0.
      cyc(8'h01, 8'h01, 8'h01, 8'h00);
      chk("tog1", {7'd0, q_w[2][0]}, 8'h01);
      cyc(8'h01, 8'h01, 8'h01, 8'h00);
      chk("tog2", {7'd0, q_w[2][0]}, 8'h00);
      cyc(8'h01, 8'h01, 8'h01, 8'h00);
      chk("tog3", {7'd0, q_w[2][0]}, 8'h01);
      chk("tog_cf", {7'd0, cf_w[2][0]}, 8'h01);
      chk("tog_count", cnt_w[2], CNT_EN ? 8'd3 : 8'd0);

      // Saturation of the 2-bit counter: conflicts on channels 0 and 5.
      do_clear();
      exp_cnt = '{1, 2, 3, 3, 3, 3};
      for (int k = 0; k < 6; k++) begin
         cyc(8'h21, 8'h21, 8'h21, 8'h00);
         chk($sformatf("sat_cnt%0d", k), cnt_w[2], CNT_EN ? 8'(exp_cnt[k]) : 8'd0);
         chk($sformatf("wide_cnt%0d", k), cnt_w[0], CNT_EN ? 8'(k + 1) : 8'd0);
      end

      // Acknowledge racing a new conflict, then a clean acknowledge.
      cyc(8'h04, 8'h04, 8'h04, 8'h00);
      chk("ack_set", {7'd0, cf_w[0][2]}, 8'h01);
      cyc(8'h04, 8'h04, 8'h04, 8'h04);
      chk("ack_vs_set", {7'd0, cf_w[0][2]}, 8'h01);
      cyc(8'h00, 8'h00, 8'h00, 8'h04);
      chk("ack_clear", {7'd0, cf_w[0][2]}, 8'h00);
      chk("ack_others", cf_w[0], 8'h21);

      // Disabled channels ignore activity on S and R.
      saved = q_w[0];
      for (int k = 0; k < 20; k++) begin
         cyc(8'h00, 8'($urandom), 8'($urandom), 8'h00);
         chk("en0_Q", q_w[0], saved);
         chk("en0_rise", rise_w[0], 8'h00);
         chk("en0_Qbar", qb_w[0], ~saved);
      end

      // S=R=1 on every channel from Q=0F under each mode.
      cyc(8'hFF, 8'h0F, 8'hF0, 8'h00);
      cyc(8'hFF, 8'hFF, 8'hFF, 8'h00);
      chk("both_m0", q_w[0], 8'h00);
      chk("both_m1", q_w[1], 8'hFF);
      chk("both_m2", q_w[2], 8'hF0);
      chk("both_m3", q_w[3], 8'h0F);
      chk("both_rise_m2", rise_w[2], 8'hF0);
      cyc(8'h00, 8'h00, 8'h00, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
